// File: rtl/sram_arb.sv
// Two-master (CPU, DMA) arbiter in front of a single-port synchronous SRAM.
// CPU has priority; a DMA starve counter forces a DMA grant after STARVE_LIMIT denied cycles.
module sram_arb #(
   parameter int unsigned STARVE_LIMIT = 32'd8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic [15:0] sram_ADDR,
   output logic [31:0] sram_DI,
   output logic        sram_EN,
   output logic        sram_WE,
   input  logic [31:0] sram_DO
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      DMA_RD = 2'd2
   } state_t;

   localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

   state_t     state_r;
   state_t     state_next_s;
   logic [7:0] starve_r;
   logic       dma_pri_s;
   logic       cpu_gnt_s;
   logic       dma_gnt_s;

   // Grant decision; reset is folded in so nothing is granted while it is held.
   always_comb begin
      dma_pri_s = 1'b0;
      cpu_gnt_s = 1'b0;
      dma_gnt_s = 1'b0;
      if (reset) begin
         dma_pri_s = dma_req && (starve_r >= LIMIT_C);
         cpu_gnt_s = cpu_req && !dma_pri_s;
         dma_gnt_s = dma_req && !cpu_gnt_s;
      end else begin
         dma_pri_s = 1'b0;
         cpu_gnt_s = 1'b0;
         dma_gnt_s = 1'b0;
      end
   end

   // Next-state and output decode: SRAM mux from the grant, read return from the state.
   always_comb begin
      state_next_s = IDLE;
      sram_EN      = 1'b0;
      sram_WE      = 1'b0;
      sram_ADDR    = 16'd0;
      sram_DI      = 32'd0;
      cpu_rvalid   = 1'b0;
      cpu_rdata    = 32'd0;
      dma_rvalid   = 1'b0;
      dma_rdata    = 32'd0;
      cpu_gnt      = cpu_gnt_s;
      dma_gnt      = dma_gnt_s;

      if (cpu_gnt_s) begin
         sram_EN   = 1'b1;
         sram_WE   = cpu_we;
         sram_ADDR = cpu_addr;
         if (cpu_we) begin
            sram_DI      = cpu_wdata;
            state_next_s = IDLE;
         end else begin
            sram_DI      = 32'd0;
            state_next_s = CPU_RD;
         end
      end else if (dma_gnt_s) begin
         sram_EN   = 1'b1;
         sram_WE   = dma_we;
         sram_ADDR = dma_addr;
         if (dma_we) begin
            sram_DI      = dma_wdata;
            state_next_s = IDLE;
         end else begin
            sram_DI      = 32'd0;
            state_next_s = DMA_RD;
         end
      end else begin
         state_next_s = IDLE;
      end

      // The previous cycle's read returns regardless of what is granted now.
      case (state_r)
         CPU_RD: begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = sram_DO;
         end
         DMA_RD: begin
            dma_rvalid = 1'b1;
            dma_rdata  = sram_DO;
         end
         IDLE: begin
            cpu_rvalid = 1'b0;
            dma_rvalid = 1'b0;
         end
         default: begin
            cpu_rvalid = 1'b0;
            dma_rvalid = 1'b0;
         end
      endcase
   end

   // Read-in-flight state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // DMA starve counter: counts denied DMA cycles, saturates at 255.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_r <= 8'd0;
      end else if (dma_req && !dma_gnt_s) begin
         if (starve_r != 8'hFF) begin
            starve_r <= starve_r + 8'd1;
         end else begin
            starve_r <= starve_r;
         end
      end else begin
         starve_r <= 8'd0;
      end
   end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: vector table for single-cycle behaviour plus
// hand-written sequences for reset, starvation and reset-during-read.
module tb_sram_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [15:0] cpu_addr;
   logic [31:0] cpu_wdata, cpu_rdata;
   logic        dma_req, dma_we, dma_gnt, dma_rvalid;
   logic [15:0] dma_addr;
   logic [31:0] dma_wdata, dma_rdata;
   logic [15:0] sram_ADDR;
   logic [31:0] sram_DI, sram_DO;
   logic        sram_EN, sram_WE;

   logic [31:0] mem [0:65535];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   sram_arb #(.STARVE_LIMIT(32'd8)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE),
      .sram_DO(sram_DO)
   );

   // Synchronous single-port SRAM: read data appears the cycle after EN.
   always @(posedge clk) begin
      if (sram_EN) begin
         if (sram_WE) mem[sram_ADDR] <= sram_DI;
         else         sram_DO <= mem[sram_ADDR];
      end
   end

   typedef struct {
      logic cr; logic cw; logic [15:0] ca; logic [31:0] cd;
      logic dr; logic dw; logic [15:0] da; logic [31:0] dd;
      logic e_cg; logic e_dg; logic e_en; logic e_we; logic [15:0] e_addr; logic [31:0] e_di;
      logic e_crv; logic [31:0] e_crd; logic e_drv; logic [31:0] e_drd;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
      dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dd;
   endtask

   task automatic set_idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 32'h0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 32'h0;
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      check({tag, ".cpu_gnt"},    {31'd0, cpu_gnt},    {31'd0, v.e_cg});
      check({tag, ".dma_gnt"},    {31'd0, dma_gnt},    {31'd0, v.e_dg});
      check({tag, ".sram_EN"},    {31'd0, sram_EN},    {31'd0, v.e_en});
      check({tag, ".sram_WE"},    {31'd0, sram_WE},    {31'd0, v.e_we});
      check({tag, ".sram_ADDR"},  {16'd0, sram_ADDR},  {16'd0, v.e_addr});
      check({tag, ".sram_DI"},    sram_DI,             v.e_di);
      check({tag, ".cpu_rvalid"}, {31'd0, cpu_rvalid}, {31'd0, v.e_crv});
      check({tag, ".cpu_rdata"},  cpu_rdata,           v.e_crd);
      check({tag, ".dma_rvalid"}, {31'd0, dma_rvalid}, {31'd0, v.e_drv});
      check({tag, ".dma_rdata"},  dma_rdata,           v.e_drd);
   endtask

   task automatic check_all_zero(input string tag);
      vec_t z;
      z = '{1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0,
            1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
      check_vec(tag, z);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      mem[16'h0010] = 32'hDEADBEEF;
      mem[16'h0001] = 32'h11111111;
      mem[16'h0002] = 32'h22222222;
      mem[16'hFFFF] = 32'hCAFEF00D;
      sram_DO = 32'h0;

      //           cr    cw    ca        cd            dr    dw    da        dd            cg    dg    en    we    addr      di            crv   crd           drv   drd
      vecs[0]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b1, 16'h0100, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 32'h12345678, 1'b0, 32'h0,        1'b0, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 16'h0100, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vecs[5]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h12345678};
      vecs[6]  = '{1'b1, 1'b0, 16'h0001, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 16'h0002, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 32'h0,        1'b1, 32'h22222222};
      vecs[9]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vecs[10] = '{1'b1, 1'b1, 16'h0010, 32'hA5A5A5A5, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 32'hA5A5A5A5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vecs[12] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, 32'h0};
      vecs[13] = '{1'b1, 1'b0, 16'h0001, 32'h0,        1'b1, 1'b1, 16'h0003, 32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vecs[14] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'h0};
      vecs[15] = '{1'b1, 1'b0, 16'hFFFF, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
      vecs[16] = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 32'h0};

      // Reset held with both masters requesting: everything must stay quiet.
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 32'hFFFFFFFF;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h4321; dma_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      check_all_zero("reset_a");
      @(negedge clk);
      check_all_zero("reset_b");
      #1;
      set_idle();
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i]);
         @(negedge clk);
         check_vec($sformatf("vec%0d", i), vecs[i]);
         @(posedge clk); #1;
      end

      // Contention: CPU reads 0x0001, DMA writes 0x0200; DMA wins every 9th cycle.
      for (int c = 0; c < 20; c++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001; cpu_wdata = 32'h0;
         dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 32'h5A5A0200;
         @(negedge clk);
         check($sformatf("starve%0d.cpu_gnt", c), {31'd0, cpu_gnt}, (c % 9 == 8) ? 32'd0 : 32'd1);
         check($sformatf("starve%0d.dma_gnt", c), {31'd0, dma_gnt}, (c % 9 == 8) ? 32'd1 : 32'd0);
         check($sformatf("starve%0d.sram_ADDR", c), {16'd0, sram_ADDR},
               (c % 9 == 8) ? 32'h0000_0200 : 32'h0000_0001);
         check($sformatf("starve%0d.sram_WE", c), {31'd0, sram_WE}, (c % 9 == 8) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end
      set_idle();
      @(negedge clk);
      check("post_starve.cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      check("post_starve.cpu_rdata", cpu_rdata, 32'h11111111);
      @(posedge clk); #1;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
      @(negedge clk);
      check("dma_rd200.dma_gnt", {31'd0, dma_gnt}, 32'd1);
      @(posedge clk); #1;
      set_idle();
      @(negedge clk);
      check("dma_rd200.dma_rvalid", {31'd0, dma_rvalid}, 32'd1);
      check("dma_rd200.dma_rdata", dma_rdata, 32'h5A5A0200);
      @(posedge clk); #1;

      // Reset pulsed between a CPU read grant and its return cycle.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      @(negedge clk);
      check("rst_mid.grant", {31'd0, cpu_gnt}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0055; dma_wdata = 32'h55555555;
      #1;
      check_all_zero("rst_mid.during");
      #1;
      reset = 1'b1;
      set_idle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
      @(negedge clk);
      check("rst_mid.rvalid_gone", {31'd0, cpu_rvalid}, 32'd0);
      check("rst_mid.rdata_zero", cpu_rdata, 32'h0);
      check("rst_mid.first_gnt", {31'd0, cpu_gnt}, 32'd1);
      check("rst_mid.first_addr", {16'd0, sram_ADDR}, 32'h0000_0002);
      @(posedge clk); #1;
      set_idle();
      @(negedge clk);
      check("rst_mid.new_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      check("rst_mid.new_rdata", cpu_rdata, 32'h22222222);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check($sformatf("rst_mid.quiet%0d", k), {31'd0, cpu_rvalid}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8: consecutive denied DMA cycles before DMA takes priority; legal range 1..255.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have CPU request ports cpu_req/cpu_we  input  1 each  access request / write-not-read.
REQ-005 The block SHALL have CPU payload ports cpu_addr  input  16 and cpu_wdata  input  32, holding word address and write data.
REQ-006 The block SHALL have CPU response ports cpu_gnt  output  1  (access accepted this cycle), cpu_rvalid  output  1 and cpu_rdata  output  32  (read data valid).
REQ-007 The block SHALL have DMA ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, with the same directions, widths and meanings as the CPU ports.
REQ-008 The block SHALL have SRAM ports sram_ADDR  output  16, sram_DI  output  32, sram_EN  output  1, sram_WE  output  1, and sram_DO  input  32 (read data one cycle after a read is enabled).

Function
REQ-009 The block SHALL issue at most one SRAM access per cycle, driving sram_* combinationally from the granted requester in the same cycle.
REQ-010 With no grant in a cycle, the block SHALL drive sram_EN=0, sram_WE=0, sram_ADDR=0 and sram_DI=0.
REQ-011 Default priority SHALL be CPU over DMA: if both request, cpu_gnt=1 and dma_gnt=0.
REQ-012 An 8-bit starve counter SHALL increment, saturating at 255, on every cycle with dma_req=1 and dma_gnt=0, and SHALL clear on any dma_gnt=1 or any cycle with dma_req=0.
REQ-013 When the starve counter is >= STARVE_LIMIT and dma_req=1, DMA SHALL win over CPU that cycle; cpu_gnt=0 and the CPU holds its request.
REQ-014 A requester SHALL hold req, we, addr and wdata stable until it sees gnt=1; gnt SHALL be a single-cycle acknowledge per access.
REQ-015 A granted write SHALL drive sram_EN=1, sram_WE=1, sram_ADDR=addr and sram_DI=wdata, and SHALL produce no rvalid.
REQ-016 A granted read SHALL drive sram_EN=1, sram_WE=0 and sram_ADDR=addr.
REQ-017 The cycle after a granted read, the owner's rvalid SHALL be 1 and its rdata SHALL equal sram_DO.
REQ-018 A non-owner's rdata SHALL be 0, and the owner's rvalid SHALL be 0 in every other cycle.
REQ-019 The block SHALL use a 3-state FSM that tracks the read in flight: IDLE, CPU_RD, DMA_RD.
REQ-020 The FSM SHALL transition on every edge: CPU read granted -> CPU_RD; DMA read granted -> DMA_RD; write granted or no grant -> IDLE.
REQ-021 Back-to-back reads SHALL be supported: a new grant in CPU_RD/DMA_RD is legal, and the rvalid for the previous read is still returned in that cycle.
REQ-022 A read in flight SHALL NOT be blocked or corrupted by a write granted in the following cycle.
REQ-023 A requester dropping req without a grant SHALL be legal and SHALL have no side effect other than clearing the DMA starve counter.
REQ-024 Addresses SHALL be passed unmodified, with no wrap or range checking.

Reset
REQ-025 While reset=0, the FSM SHALL be IDLE, the starve counter 0, gnt/rvalid 0, rdata 0, and sram_EN/WE/ADDR/DI 0, regardless of the clock or requests.
REQ-026 When reset asserts mid-read, the pending rvalid SHALL be discarded and no rvalid SHALL appear after release.
REQ-027 After reset deasserts, arbitration SHALL begin on the first rising clk edge, with requests honoured from the first cycle.

Verification
REQ-028 The bench SHALL check CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x0010, mem[0x10]=0xDEADBEEF -> cpu_gnt=1, sram_EN=1, sram_WE=0, then next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
REQ-029 The bench SHALL check contention: cpu_req and dma_req both held for 20 cycles, STARVE_LIMIT=8 -> CPU granted cycles 0-7, DMA granted cycle 8, counter cleared, pattern repeats with period 9.
REQ-030 The bench SHALL check DMA write: dma_req=1, dma_we=1, dma_addr=0x0100, dma_wdata=0x12345678, CPU idle -> dma_gnt=1, sram_WE=1, sram_DI=0x12345678, no dma_rvalid; a later read of 0x0100 returns 0x12345678.
REQ-031 The bench SHALL check back-to-back reads: CPU read 0x0001 then DMA read 0x0002 on consecutive cycles -> cpu_rvalid in cycle 1 and dma_rvalid in cycle 2, each with the correct data and the other's rvalid=0.
REQ-032 The bench SHALL check reset mid-read: reset=0 pulsed between a CPU read grant and its return cycle -> no cpu_rvalid ever for that read, all outputs 0 during reset, and a normal grant on the first request after release.
